// File: rtl/svm_pkg.sv
// Shared types and default widths for the vector streamer.
package svm_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned LEN_W_DEF  = 16;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Framing that travels with an element through the read pipeline
  typedef struct packed {
    logic valid;
    logic first;  // element 0 of a vector
    logic eov;    // last element of a vector
    logic fin;    // last element of the whole command
  } frame_t;

endpackage

// File: rtl/vector_streamer_if.sv
// Command and element-stream bundle of the vector streamer.
// With STREAMER_STALL_EN defined the stream gains an out_ready back-pressure signal.
interface vector_streamer_if #(
  parameter int unsigned LEN_W = svm_pkg::LEN_W_DEF
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [LEN_W-1:0]    cmd_len;
  logic [LEN_W-1:0]    cmd_count;
  logic signed [31:0]  out_test;
  logic signed [31:0]  out_support;
  logic                out_start;
  logic                out_end;
  logic                out_valid;
`ifdef STREAMER_STALL_EN
  logic                out_ready;

  modport master (
    output cmd_valid, cmd_len, cmd_count, out_ready,
    input  cmd_ready, out_test, out_support, out_start, out_end, out_valid
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_count, out_ready,
    output cmd_ready, out_test, out_support, out_start, out_end, out_valid
  );
`else
  modport master (
    output cmd_valid, cmd_len, cmd_count,
    input  cmd_ready, out_test, out_support, out_start, out_end, out_valid
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_count,
    output cmd_ready, out_test, out_support, out_start, out_end, out_valid
  );
`endif

endinterface

// File: rtl/streamer_addr_gen.sv
// Element/vector counters and running support-vector pointer; its registers
// form the address-issue stage of the streamer pipeline.
module streamer_addr_gen
  import svm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W-1:0]  count,
  input  logic              step,
  output logic              valid,
  output logic [ADDR_W-1:0] test_addr,
  output logic [ADDR_W-1:0] sv_addr,
  output logic              first_c,
  output logic              eov_c,
  output logic              last_c
);

  logic              valid_q, valid_d;
  logic [LEN_W-1:0]  elem_q, elem_d;
  logic [LEN_W-1:0]  vec_q, vec_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign first_c = (elem_q == '0);
  assign eov_c   = (elem_q == len_q - LEN_W'(1));
  assign last_c  = eov_c && (vec_q == cnt_q - LEN_W'(1));

  assign valid     = valid_q;
  assign test_addr = ADDR_W'(elem_q);
  assign sv_addr   = ptr_q;

  // Load on accept, then advance one element per enabled cycle; pointer runs j*len+i
  always_comb begin
    valid_d = valid_q;
    elem_d  = elem_q;
    vec_d   = vec_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      elem_d  = '0;
      vec_d   = '0;
      ptr_d   = '0;
      len_d   = len;
      cnt_d   = count;
    end else if (step && valid_q) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (eov_c) begin
        elem_d = '0;
        if (last_c) begin
          valid_d = 1'b0;
        end else begin
          vec_d = vec_q + LEN_W'(1);
        end
      end else begin
        elem_d = elem_q + LEN_W'(1);
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      elem_q  <= '0;
      vec_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      elem_q  <= elem_d;
      vec_q   <= vec_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/vector_streamer.sv
// Streams element pairs of a test vector against cmd_count support vectors
// read from two 1-cycle-latency memories, with start/end framing per vector.
// Optional STREAMER_STALL_EN adds out_ready back-pressure on the output stream.
module vector_streamer
  import svm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vector_streamer_if.slave         bus,
  output logic [ADDR_W-1:0]        test_addr,
  output logic [ADDR_W-1:0]        sv_addr,
  input  logic signed [DATA_W-1:0] test_rdata,
  input  logic signed [DATA_W-1:0] sv_rdata,
  output logic                     busy,
  output logic                     done
);

  state_e                   state_q, state_d;
  frame_t                   m_q, m_d;
  frame_t                   o_q, o_d;
  logic signed [DATA_W-1:0] out_test_q, out_test_d;
  logic signed [DATA_W-1:0] out_sv_q, out_sv_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     adv_c, xfer_c, accept_c, zero_c, load_c;
  logic                     a_valid, a_first_c, a_eov_c, a_last_c;
  logic signed [DATA_W-1:0] m_test_c, m_sv_c;

  assign accept_c = bus.cmd_valid && cmd_ready_q;
  assign zero_c   = (bus.cmd_len == '0) || (bus.cmd_count == '0);
  assign load_c   = accept_c && !zero_c;

`ifdef STREAMER_STALL_EN
  logic                     hold_q, hold_d;
  logic signed [DATA_W-1:0] hold_test_q, hold_test_d;
  logic signed [DATA_W-1:0] hold_sv_q, hold_sv_d;

  assign adv_c    = !o_q.valid || bus.out_ready;
  assign xfer_c   = o_q.valid && bus.out_ready;
  assign m_test_c = hold_q ? hold_test_q : test_rdata;
  assign m_sv_c   = hold_q ? hold_sv_q : sv_rdata;

  // While stalled the issue stage keeps re-driving its address, so the data
  // returning for the element already in the read stage is parked here once
  always_comb begin
    hold_d      = hold_q;
    hold_test_d = hold_test_q;
    hold_sv_d   = hold_sv_q;
    if (adv_c) begin
      hold_d = 1'b0;
    end else if (!hold_q) begin
      hold_d      = 1'b1;
      hold_test_d = test_rdata;
      hold_sv_d   = sv_rdata;
    end
  end

  // Stall parking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= 1'b0;
      hold_test_q <= '0;
      hold_sv_q   <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_test_q <= hold_test_d;
      hold_sv_q   <= hold_sv_d;
    end
  end
`else
  assign adv_c    = 1'b1;
  assign xfer_c   = o_q.valid;
  assign m_test_c = test_rdata;
  assign m_sv_c   = sv_rdata;
`endif

  streamer_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .len       (bus.cmd_len),
    .count     (bus.cmd_count),
    .step      (adv_c),
    .valid     (a_valid),
    .test_addr (test_addr),
    .sv_addr   (sv_addr),
    .first_c   (a_first_c),
    .eov_c     (a_eov_c),
    .last_c    (a_last_c)
  );

  // FSM next state plus the read-stage and output-stage pipeline
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    o_d        = o_q;
    out_test_d = out_test_q;
    out_sv_d   = out_sv_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE:    if (load_c) state_d = RUN;
      RUN:     if (a_valid && a_last_c && adv_c) state_d = FLUSH;
      FLUSH:   if (xfer_c && o_q.fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (accept_c && zero_c) || (xfer_c && o_q.fin);

    if (adv_c) begin
      m_d.valid = a_valid;
      m_d.first = a_valid && a_first_c;
      m_d.eov   = a_valid && a_eov_c;
      m_d.fin   = a_valid && a_last_c;
      o_d       = m_q;
      if (m_q.valid) begin
        out_test_d = m_test_c;
        out_sv_d   = m_sv_c;
      end
    end

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      o_q         <= '0;
      out_test_q  <= '0;
      out_sv_q    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      o_q         <= o_d;
      out_test_q  <= out_test_d;
      out_sv_q    <= out_sv_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.out_valid   = o_q.valid;
  assign bus.out_start   = o_q.first;
  assign bus.out_end     = o_q.eov;
  assign bus.out_test    = out_test_q;
  assign bus.out_support = out_sv_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_vector_streamer.sv
// Bench for vector_streamer: table of commands checked against a beat
// scoreboard, plus reset, back-to-back and (STREAMER_STALL_EN) stall sequences.
module tb_vector_streamer;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LEN_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_streamer_if #(.LEN_W(LEN_W)) bus ();

  logic [ADDR_W-1:0] test_addr, sv_addr;
  logic signed [31:0] test_rdata, sv_rdata;
  logic busy, done;

  vector_streamer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .test_addr  (test_addr),
    .sv_addr    (sv_addr),
    .test_rdata (test_rdata),
    .sv_rdata   (sv_rdata),
    .busy       (busy),
    .done       (done)
  );

  int tmem [4096];
  int smem [4096];

  // Synchronous memories, one cycle read latency
  always @(posedge clk) begin
    test_rdata <= tmem[test_addr];
    sv_rdata   <= smem[sv_addr];
  end

  logic rdy;
`ifdef STREAMER_STALL_EN
  assign rdy = bus.out_ready;
`else
  assign rdy = 1'b1;
`endif

  typedef struct {
    int   t;
    int   s;
    logic st;
    logic en;
  } beat_t;

  typedef struct {
    int len;
    int cnt;
  } vec_t;

  beat_t  exp_q [$];
  longint exp_dot_q [$];
  longint got_dots [$];
  beat_t  mon_e;
  longint acc = 0;
  int     beat_cnt = 0;
  int     first_beat_cyc = 0;
  int     last_beat_cyc = 0;
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every transferred beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.out_valid) begin
        check("framing low off-beat", {bus.out_start, bus.out_end}, 0);
      end else if (rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat test data", bus.out_test, mon_e.t);
          check("beat sv data", bus.out_support, mon_e.s);
          check("beat framing", {bus.out_start, bus.out_end}, {mon_e.st, mon_e.en});
        end
        if (beat_cnt == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beat_cnt++;
        acc += longint'(bus.out_test) * longint'(bus.out_support);
        if (bus.out_end) begin
          got_dots.push_back(acc);
          if (exp_dot_q.size() > 0) check("kernel dot", acc, exp_dot_q.pop_front());
          acc = 0;
        end
      end
    end
  end

  task automatic push_cmd(input int len, input int cnt);
    beat_t  b;
    longint dot;
    if (len == 0 || cnt == 0) return;
    for (int j = 0; j < cnt; j++) begin
      dot = 0;
      for (int i = 0; i < len; i++) begin
        b.t  = tmem[i % 4096];
        b.s  = smem[(j * len + i) % 4096];
        b.st = (i == 0);
        b.en = (i == len - 1);
        exp_q.push_back(b);
        dot += longint'(b.t) * longint'(b.s);
      end
      exp_dot_q.push_back(dot);
    end
  endtask

  task automatic issue(input int len, input int cnt, output int acc_cyc);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready before issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_count = LEN_W'(cnt);
    push_cmd(len, cnt);
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = LEN_W'($urandom);
    bus.cmd_count = LEN_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) check("done timeout", 0, 1);
  endtask

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, d, a2, n, bad;
    logic signed [31:0] held_t, held_s;

    for (int i = 0; i < 4096; i++) begin
      tmem[i] = i + 1;
      smem[i] = i + 4;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_count = '0;
`ifdef STREAMER_STALL_EN
    bus.out_ready = 1'b1;
`endif

    // Reset state
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset test_addr", test_addr, 0);
    check("reset sv_addr", sv_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cmd_ready after reset", bus.cmd_ready, 1);
    @(negedge clk);

    tbl[0] = '{3, 2};
    tbl[1] = '{1, 3};
    tbl[2] = '{4, 0};
    tbl[3] = '{0, 5};
    tbl[4] = '{5, 4};
    tbl[5] = '{70, 60};
    tbl[6] = '{2, 1};

    for (int k = 0; k < 7; k++) begin
      beat_cnt = 0;
      got_dots.delete();
      n = tbl[k].len * tbl[k].cnt;
      issue(tbl[k].len, tbl[k].cnt, a);
      wait_done(n + 20, d);
      check("done latency", d - a, (n == 0) ? 0 : n + 2);
      check("beat count", beat_cnt, n);
      if (n > 0) begin
        check("first beat latency", first_beat_cyc - a, 2);
        check("last beat latency", last_beat_cyc - a, n + 1);
      end
      check("scoreboard drained", exp_q.size(), 0);
      check("busy at done", busy, 0);
      check("cmd_ready at done", bus.cmd_ready, 1);
      if (k == 0) begin
        check("kernel dot vec0", (got_dots.size() > 0) ? got_dots[0] : -1, 32);
        check("kernel dot vec1", (got_dots.size() > 1) ? got_dots[1] : -1, 50);
      end
      @(negedge clk);
      check("done single pulse", done, 0);
    end

    // Reset asserted while beat 2 of a 4x2 command is on the output
    beat_cnt = 0;
    issue(4, 2, a);
    repeat (4) @(posedge clk);
    #2;
    check("beat 2 on output", bus.out_valid, 1);
    check("beats before reset", beat_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", bus.out_valid, 0);
    check("mid reset out_start", bus.out_start, 0);
    check("mid reset out_end", bus.out_end, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset test_addr", test_addr, 0);
    check("mid reset sv_addr", sv_addr, 0);
    exp_q.delete();
    exp_dot_q.delete();
    acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("cmd_ready after mid reset", bus.cmd_ready, 1);
    check("no beat after mid reset", bus.out_valid, 0);
    beat_cnt = 0;
    issue(4, 2, a);
    wait_done(40, d);
    check("post-reset done latency", d - a, 10);
    check("post-reset beat count", beat_cnt, 8);
    check("post-reset first beat latency", first_beat_cyc - a, 2);
    check("post-reset drained", exp_q.size(), 0);
    @(negedge clk);

    // cmd_valid held high across a busy command
    beat_cnt = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(3);
    bus.cmd_count = LEN_W'(2);
    push_cmd(3, 2);
    @(posedge clk);
    #1;
    a = cyc;
    check("busy after accept", busy, 1);
    bus.cmd_len   = LEN_W'(2);
    bus.cmd_count = LEN_W'(1);
    bad = 0;
    d = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
      if (bus.cmd_ready) bad++;
    end
    check("cmd_ready low while busy", bad, 0);
    check("held-valid first done latency", d - a, 8);
    check("cmd_ready in done cycle", bus.cmd_ready, 1);
    push_cmd(2, 1);
    @(posedge clk);
    #1;
    a2 = cyc;
    bus.cmd_valid = 1'b0;
    check("second command accepted", busy, 1);
    wait_done(40, d);
    check("second done latency", d - a2, 4);
    check("back-to-back beat count", beat_cnt, 8);
    check("back-to-back drained", exp_q.size(), 0);
    @(negedge clk);

`ifdef STREAMER_STALL_EN
    // out_ready low for three cycles while beat 1 of a 3x1 command is presented
    beat_cnt = 0;
    issue(3, 1, a);
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("stall beat present", bus.out_valid, 1);
    held_t = bus.out_test;
    held_s = bus.out_support;
    check("stall held test value", held_t, tmem[1]);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("stall valid held", bus.out_valid, 1);
      check("stall test held", bus.out_test, held_t);
      check("stall sv held", bus.out_support, held_s);
      check("stall framing held", {bus.out_start, bus.out_end}, 0);
      if (k == 2) bus.out_ready = 1'b1;
    end
    wait_done(40, d);
    check("stall done latency", d - a, 8);
    check("stall beat count", beat_cnt, 3);
    check("stall drained", exp_q.size(), 0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
